// File: rtl/adder_accum_seq.sv
// Burst accumulator that drives an external 32-bit adder with {acc, word, cin}
// and returns the final total plus a saturating carry/borrow count.
module adder_accum_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             sub,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] remaining;
    logic             sub_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [CNT_W-1:0] out_carries_q;

    logic             beat;
    logic             carry_hit;
    logic [CNT_W-1:0] count_next;

    assign add_a   = acc;
    assign add_b   = sub_q ? ~in_data : in_data;
    assign add_cin = sub_q;

    assign in_ready    = (state == RUN);
    assign out_valid   = (state == HOLD);
    assign busy        = (state != IDLE);
    assign out_sum     = out_sum_q;
    assign out_carries = out_carries_q;

    assign beat = in_ready && in_valid;

    // In subtract mode a missing carry out of ~word+1 is a borrow.
    assign carry_hit = add_cout ^ sub_q;

    always_comb begin
        count_next = count;
        if (carry_hit && (count != '1))
            count_next = count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            remaining     <= '0;
            sub_q         <= 1'b0;
            out_sum_q     <= '0;
            out_carries_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        count     <= '0;
                        remaining <= len;
                        sub_q     <= sub;
                        if (len != '0) begin
                            state <= RUN;
                        end else begin
                            state         <= HOLD;
                            out_sum_q     <= '0;
                            out_carries_q <= '0;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        acc       <= add_sum;
                        count     <= count_next;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state         <= HOLD;
                            out_sum_q     <= add_sum;
                            out_carries_q <= count_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accum_seq.sv
// Directed bench for adder_accum_seq; models the downstream 32-bit adder.
module tb_adder_accum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        sub;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [7:0]  out_carries;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External adder_32bit stand-in
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    adder_accum_seq #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carries(out_carries), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        int budget;

        rst = 1'b1; start = 1'b0; len = '0; sub = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_carries", out_carries, 0);
        chk("rst_busy", busy, 0);
        tick;
        rst = 1'b0;
        tick;

        // 1: add 1,2,3 back-to-back
        start = 1'b1; len = 8'd3; sub = 1'b0;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd1; #1;
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy", busy, 1);
        tick; in_data = 32'd2;
        tick; in_data = 32'd3; #1;
        chk("t1_no_early_valid", out_valid, 0);
        tick; in_valid = 1'b0; #1;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_sum", out_sum, 32'd6);
        chk("t1_out_carries", out_carries, 0);
        chk("t1_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        tick; out_ready = 1'b0; #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_valid", out_valid, 0);

        // 2: carry out of the accumulator, with a one-cycle stall
        start = 1'b1; len = 8'd2; sub = 1'b0;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        tick; in_valid = 1'b0; #1;
        chk("t2_stall_ready", in_ready, 1);
        chk("t2_stall_acc", add_a, 32'hFFFF_FFFF);
        tick; in_valid = 1'b1; in_data = 32'd2;
        tick; in_valid = 1'b0; #1;
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_sum", out_sum, 32'h0000_0001);
        chk("t2_out_carries", out_carries, 1);
        out_ready = 1'b1;
        tick; out_ready = 1'b0;

        // 3: subtract 5 from 0 -> borrow
        start = 1'b1; len = 8'd1; sub = 1'b1;
        tick;
        start = 1'b0; sub = 1'b0;
        in_valid = 1'b1; in_data = 32'd5; #1;
        chk("t3_add_a", add_a, 0);
        chk("t3_add_b", add_b, 32'hFFFF_FFFA);
        chk("t3_add_cin", add_cin, 1);
        tick; in_valid = 1'b0; #1;
        chk("t3_out_sum", out_sum, 32'hFFFF_FFFB);
        chk("t3_out_carries", out_carries, 1);
        out_ready = 1'b1;
        tick; out_ready = 1'b0;

        // 4: zero-length burst
        start = 1'b1; len = 8'd0; sub = 1'b0; #1;
        chk("t4_start_in_ready", in_ready, 0);
        tick; start = 1'b0; #1;
        chk("t4_out_valid", out_valid, 1);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_out_sum", out_sum, 0);
        chk("t4_out_carries", out_carries, 0);
        out_ready = 1'b1;
        tick; out_ready = 1'b0;

        // 5: result held under backpressure, start ignored
        start = 1'b1; len = 8'd1; sub = 1'b0;
        tick;
        start = 1'b0; in_valid = 1'b1; in_data = 32'h1234;
        tick; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = i[0]; len = 8'd5; sub = 1'b1; #1;
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_sum", out_sum, 32'h1234);
            chk("t5_hold_in_ready", in_ready, 0);
            tick;
        end
        start = 1'b0; out_ready = 1'b1;
        tick; out_ready = 1'b0; #1;
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_valid", out_valid, 0);
        tick; #1;
        chk("t5_start_not_queued", busy, 0);

        // 6: reset mid-burst with random in_valid
        start = 1'b1; len = 8'd4; sub = 1'b0;
        tick; start = 1'b0;
        accepted = 0;
        budget = 0;
        while (accepted < 2 && budget < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 32'd100 + 32'(budget);
            #1;
            if (in_valid && in_ready) accepted++;
            tick;
            budget++;
        end
        chk("t6_two_beats_accepted", accepted, 2);
        in_valid = 1'($urandom_range(0, 1));
        #2 rst = 1'b1; #1;
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_sum", out_sum, 0);
        chk("t6_rst_carries", out_carries, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_acc", add_a, 0);
        in_valid = 1'b0;
        tick; rst = 1'b0;
        tick;
        start = 1'b1; len = 8'd1; sub = 1'b0;
        tick; start = 1'b0;
        in_valid = 1'b1; in_data = 32'd7;
        tick; in_valid = 1'b0; #1;
        chk("t6_new_valid", out_valid, 1);
        chk("t6_new_sum", out_sum, 32'd7);
        chk("t6_new_carries", out_carries, 0);
        out_ready = 1'b1;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
